mux4_rr_sched: RTL and testbench

- Round-robin scheduler that shares a single 4:1 mux output channel among four requesters.
- Arbitrates the requests, drives the 2-bit mux select and a one-hot grant, and forwards the selected data word to one downstream consumer using a valid/ready handshake.
- Limits each grant to a bounded burst so that no requester can hold the channel indefinitely.

---
 rtl/mux4_rr_sched.sv | 116 +++++++++++
 tb/tb_mux4_rr_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux channel among four requesters.
// Bursts are capped at BURST_LEN transfers; release re-arbitrates in place.
module mux4_rr_sched #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] data_in,
    input  logic                dout_ready,
    output logic [3:0]          gnt,
    output logic [1:0]          sel,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                busy
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [3:0] BURST = 4'(BURST_LEN);

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;

    logic [2:0] win;
    logic [1:0] rel_ptr;
    logic [3:0] cnt_inc;
    logic       xfer;
    logic       rel;

    // Returns {found, index}; lowest offset from p wins.
    function automatic logic [2:0] arb(input logic [3:0] r,
                                       input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        win     = 3'b000;
        xfer    = dout_valid & dout_ready;
        cnt_inc = cnt_q + 4'(xfer);
        rel_ptr = sel_q + 2'd1;
        rel     = !req[sel_q] || (xfer && cnt_inc == BURST);
        unique case (state_q)
            IDLE: begin
                win = arb(req, ptr_q);
                if (win[2]) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win[1:0];
                    sel_d   = win[1:0];
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                if (rel) begin
                    // Old owner stays eligible, just at lowest priority.
                    ptr_d = rel_ptr;
                    win   = arb(req, rel_ptr);
                    cnt_d = 4'd0;
                    if (win[2]) begin
                        gnt_d = 4'b0001 << win[1:0];
                        sel_d = win[1:0];
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == GRANT);
        dout_valid = busy & req[sel_q];
        dout       = '0;
        if (dout_valid)
            dout = data_in[int'(sel_q)*DATA_W +: DATA_W];
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: vector table for rotation and
// sole-requester bursts, hand sequences for drop, stall and async reset.
module tb_mux4_rr_sched;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] data_in;
    logic           dout_ready;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           busy;

    int n_pass;
    int n_total;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       valid;
    } vec_t;

    vec_t tbl[33];

    mux4_rr_sched #(.DATA_W(W), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .dout_ready (dout_ready),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected dout for requester s
    function automatic logic [7:0] dat(input logic [1:0] s);
        return 8'hA0 + 8'(s);
    endfunction

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        req        = 4'b1111;
        dout_ready = 1'b1;
        data_in    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // All four requesting, full throughput: 4 beats each, 0,1,2,3,0
        for (int k = 0; k < 20; k++) begin
            tbl[k].req   = 4'b1111;
            tbl[k].rdy   = 1'b1;
            tbl[k].sel   = 2'((k / 4) % 4);
            tbl[k].gnt   = 4'b0001 << ((k / 4) % 4);
            tbl[k].busy  = 1'b1;
            tbl[k].valid = 1'b1;
        end
        // Only requester 2: re-granted back-to-back, busy never drops
        for (int k = 20; k < 32; k++) begin
            tbl[k].req   = 4'b0100;
            tbl[k].rdy   = 1'b1;
            tbl[k].sel   = 2'd2;
            tbl[k].gnt   = 4'b0100;
            tbl[k].busy  = 1'b1;
            tbl[k].valid = 1'b1;
        end
        tbl[32].req   = 4'b0000;
        tbl[32].rdy   = 1'b1;
        tbl[32].sel   = 2'd2;
        tbl[32].gnt   = 4'b0000;
        tbl[32].busy  = 1'b0;
        tbl[32].valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_sel", 32'(sel), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_valid", 32'(dout_valid), 32'h0);
            chk("rst_dout", 32'(dout), 32'h0);
        end
        rst = 1'b0;

        for (int k = 0; k < 33; k++) begin
            req        = tbl[k].req;
            dout_ready = tbl[k].rdy;
            step();
            chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(tbl[k].gnt));
            chk($sformatf("v%0d_sel", k), 32'(sel), 32'(tbl[k].sel));
            chk($sformatf("v%0d_busy", k), 32'(busy),
                32'(tbl[k].busy));
            chk($sformatf("v%0d_valid", k), 32'(dout_valid),
                32'(tbl[k].valid));
            chk($sformatf("v%0d_dout", k), 32'(dout),
                tbl[k].valid ? 32'(dat(tbl[k].sel)) : 32'h0);
        end

        // Requester 1 drops after 2 beats; ptr=2 must pick 3 over 0
        req = 4'b0010;
        step();
        chk("drop_g1", 32'(gnt), 32'h2);
        chk("drop_s1", 32'(sel), 32'h1);
        req = 4'b1010;
        step();
        step();
        chk("drop_hold", 32'(gnt), 32'h2);
        req = 4'b1001;
        step();
        chk("drop_gnt", 32'(gnt), 32'h8);
        chk("drop_sel", 32'(sel), 32'h3);
        chk("drop_dout", 32'(dout), 32'hA3);

        req = 4'b0000;
        step();
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Back-pressure on requester 0 for 10 cycles
        req        = 4'b0001;
        dout_ready = 1'b0;
        step();
        chk("bp_gnt0", 32'(gnt), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp%0d_gnt", i), 32'(gnt), 32'h1);
            chk($sformatf("bp%0d_valid", i), 32'(dout_valid), 32'h1);
            chk($sformatf("bp%0d_dout", i), 32'(dout), 32'hA0);
        end
        req        = 4'b0011;
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bpx%0d_gnt", i), 32'(gnt), 32'h1);
        end
        step();
        chk("bp_rot_gnt", 32'(gnt), 32'h2);
        chk("bp_rot_sel", 32'(sel), 32'h1);

        // Async reset mid-burst (cnt=2), then restart from ptr=0
        req = 4'b1111;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_sel", 32'(sel), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_valid", 32'(dout_valid), 32'h0);
        chk("ar_dout", 32'(dout), 32'h0);
        #2;
        rst = 1'b0;
        step();
        chk("ar_re_gnt", 32'(gnt), 32'h1);
        chk("ar_re_sel", 32'(sel), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
